// File: rtl/uart_rx_checker.sv
// UART receive checker: synchronises rx_in, deserialises and validates frames, buffers
// accepted bytes in a FIFO and keeps sticky framing/parity/overrun flags.
module uart_rx_checker #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          rx_in,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clr,
  output logic [15:0]                   byte_cnt
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitIdle} state_e;
  state_e r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [TW-1:0]          r_timer;
  logic [3:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_stop_bad, r_par_bad, r_frame_done;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count, w_count_next;
  logic                   r_empty, r_full, r_rd_valid;
  logic [DATA_BITS-1:0]   r_rd_data;
  logic                   r_frame_err, r_parity_err, r_overrun_err;
  logic [15:0]            r_byte_cnt;

  logic w_rx_s, w_fall, w_tick, w_half, w_par_exp;
  logic w_push, w_pop, w_wr, w_overrun;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_rx_prev & ~w_rx_s;
  assign w_tick    = (r_timer == TIMER_LAST);
  assign w_half    = (r_timer == TIMER_HALF);
  assign w_par_exp = (PARITY == 1) ? ~^r_shift : ^r_shift;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_in};
      r_rx_prev <= w_rx_s;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_fall) w_state_next = StStart;
      StStart:    if (w_half) w_state_next = w_rx_s ? StIdle : StData;
      StData:     if (w_tick && r_bit_idx == DATA_LAST)
                    w_state_next = (PARITY != 0) ? StParity : StStop;
      StParity:   if (w_tick) w_state_next = StStop;
      StStop:     if (w_tick && r_bit_idx == STOP_LAST)
                    w_state_next = (r_stop_bad | ~w_rx_s) ? StWaitIdle : StIdle;
      StWaitIdle: if (w_rx_s) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    rx_busy = (r_state != StIdle);
  end

  // Bit timer, shift register and per-frame status; r_frame_done marks the disposition cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_stop_bad   <= 1'b0;
      r_par_bad    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_timer    <= '0;
          r_bit_idx  <= '0;
          r_stop_bad <= 1'b0;
          r_par_bad  <= 1'b0;
        end
        StStart: r_timer <= w_half ? '0 : r_timer + 1'b1;
        StData: begin
          if (w_tick) begin
            r_timer   <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= (r_bit_idx == DATA_LAST) ? '0 : r_bit_idx + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StParity: begin
          if (w_tick) begin
            r_timer   <= '0;
            r_par_bad <= (w_rx_s != w_par_exp);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StStop: begin
          if (w_tick) begin
            r_timer      <= '0;
            r_bit_idx    <= r_bit_idx + 1'b1;
            r_stop_bad   <= r_stop_bad | ~w_rx_s;
            r_frame_done <= (r_bit_idx == STOP_LAST);
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_timer <= '0;
      endcase
    end
  end

  assign w_push    = r_frame_done & ~r_stop_bad & ~r_par_bad;
  assign w_pop     = rd_en & ~r_empty;
  assign w_wr      = w_push & (~r_full | w_pop);
  assign w_overrun = w_push & r_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop)      w_count_next = r_count + 1'b1;
    else if (w_pop && !w_wr) w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == (AW+1)'(FIFO_DEPTH));
    end
  end

  // Sticky flags: a coincident error event beats err_clr.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
      r_byte_cnt    <= '0;
    end else begin
      if (r_frame_done && r_stop_bad)                  r_frame_err <= 1'b1;
      else if (err_clr)                                r_frame_err <= 1'b0;
      if (r_frame_done && !r_stop_bad && r_par_bad)    r_parity_err <= 1'b1;
      else if (err_clr)                                r_parity_err <= 1'b0;
      if (w_overrun)                                   r_overrun_err <= 1'b1;
      else if (err_clr)                                r_overrun_err <= 1'b0;
      if (w_push && r_byte_cnt != 16'hFFFF)            r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign fifo_empty  = r_empty;
  assign fifo_full   = r_full;
  assign fifo_count  = r_count;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun_err = r_overrun_err;
  assign byte_cnt    = r_byte_cnt;

endmodule
